regfile_wr_sched: RTL and testbench
===================================

// Module: regfile_wr_sched
// PURPOSE
//   Write-port scheduler for the 32x32 register file (REG). After reset it sequences a
//   clear sweep writing 0 to r1..r31, then shares the single write port (wn/datain/wreg)
//   between two writeback requesters (A = ALU, B = memory/load) with valid/ready handshakes.
//   It uses round-robin arbitration. Sits between the writeback stage and REG's write port.
// PARAMETERS
//   DATA_W          32  width of write data
//   ADDR_W          5   register index width; file depth = 2**ADDR_W
//   CLEAR_ON_RESET  1   1: run clear sweep after reset; 0: go straight to RUN
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high reset
//   a_valid    in   1       requester A has a write pending
//   a_ready    out  1       A's write is accepted this cycle (comb)
//   a_wn       in   ADDR_W  A's destination register
//   a_data     in   DATA_W  A's write data
//   b_valid    in   1       requester B has a write pending
//   b_ready    out  1       B's write is accepted this cycle (comb)
//   b_wn       in   ADDR_W  B's destination register
//   b_data     in   DATA_W  B's write data
//   wn         out  ADDR_W  REG write address (registered)
//   datain     out  DATA_W  REG write data (registered)
//   wreg       out  1       REG write enable (registered)
//   init_done  out  1       1 once clear sweep finished (registered)
// BEHAVIOUR
//   Reset: wn=0, datain=0, wreg=0, init_done=0, a_ready=b_ready=0.
//     Sweep counter=1, RR pointer favours A.
//     State=CLEAR if CLEAR_ON_RESET else RUN. In the RUN case, init_done=1 from the first edge.
//   FSM CLEAR: each edge registers wreg=1, wn=cnt, datain=0, cnt++.
//     After edge with wn=2**ADDR_W-1 (31) -> RUN.
//     Next edge: wreg=0, init_done=1. Sweep = 31 cycles; r0 never written.
//     a_ready=b_ready=0 throughout CLEAR.
//   FSM RUN (terminal until reset): transfer = valid & ready, at most one per cycle.
//     Only A valid -> a_ready=1. Only B valid -> b_ready=1.
//     Both valid -> grant the requester NOT served by the last transfer.
//       The RR pointer updates only on a transfer.
//     ready depends only on valid and the pointer; requesters hold valid/wn/data until ready.
//   Latency: a transfer at edge N appears on wn/datain with wreg=1 after edge N.
//     It is written to REG at edge N+1. Back-to-back transfers each cycle give full throughput.
//   wn==0 request: accepted (ready=1, pointer updates) but registers wreg=0; r0 stays 0.
//   No transfer: wreg=0; wn/datain hold their previous values.
//   Both requesters target the same wn: written in grant order on consecutive cycles.
//     Last granted data wins.
//   reset asserted mid-CLEAR or mid-RUN: all state/outputs go to reset values immediately.
//     The sweep restarts at r1 after release.
// TESTING
//   1 reset 0->1->0, idle inputs -> wn steps 1..31 with wreg=1, datain=0 on 31 consecutive edges;
//     then wreg=0, init_done=1; a_ready=b_ready=0 during sweep.
//   2 after init, A only: a_wn=1, a_data=FFFFFFFF for 1 cycle -> a_ready=1;
//     next cycle wn=1, datain=FFFFFFFF, wreg=1, then wreg=0.
//   3 A and B valid for 4 cycles (A: r2=0000F00F, r3=FF00FF00; B: r4=AA0000AA, r5=12345678)
//     -> grants A,B,A,B; wn 2,4,3,5 on consecutive cycles.
//   4 B valid with b_wn=0, b_data=DEADBEEF -> b_ready=1, following cycle wreg=0.
//   5 A and B both target r7 (A=11111111, B=22222222), pointer favouring A
//     -> r7 written 11111111 then 22222222.
//   6 assert reset while sweep at wn=10 -> outputs zero immediately;
//     after release sweep restarts at wn=1, init_done=0 until 31 writes done.

Source files
------------

// File: rtl/regfile_wr_sched_if.sv
// rtl/regfile_wr_sched_if.sv - requester handshakes and register-file write port of the write scheduler
interface regfile_wr_sched_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_wn;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_wn;
    logic [DATA_W-1:0] b_data;
    logic [ADDR_W-1:0] wn;
    logic [DATA_W-1:0] datain;
    logic              wreg;
    logic              init_done;

    modport master (
        output a_valid, a_wn, a_data, b_valid, b_wn, b_data,
        input  a_ready, b_ready, wn, datain, wreg, init_done
    );

    modport slave (
        input  a_valid, a_wn, a_data, b_valid, b_wn, b_data,
        output a_ready, b_ready, wn, datain, wreg, init_done
    );
endinterface

// File: rtl/regfile_wr_sched.sv
// rtl/regfile_wr_sched.sv - clear sweep then round-robin sharing of the register-file write port
module regfile_wr_sched #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wr_sched_if.slave  port
);
    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              ptr_a;
    logic              a_go;
    logic              b_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? CLEAR : RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ptr_a set means A wins a tie, i.e. B was served by the last transfer
    always_comb begin
        state_nxt = state;
        a_go      = 1'b0;
        b_go      = 1'b0;
        case (state)
            CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                a_go = port.a_valid && (!port.b_valid || ptr_a);
                b_go = port.b_valid && (!port.a_valid || !ptr_a);
            end
            default: state_nxt = state;
        endcase
    end

    assign port.a_ready = a_go;
    assign port.b_ready = b_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt            <= ADDR_W'(1);
            ptr_a          <= 1'b1;
            port.wn        <= '0;
            port.datain    <= '0;
            port.wreg      <= 1'b0;
            port.init_done <= 1'b0;
        end else begin
            port.init_done <= (state == RUN);
            port.wreg      <= 1'b0;
            if (state == CLEAR) begin
                port.wreg   <= 1'b1;
                port.wn     <= cnt;
                port.datain <= '0;
                cnt         <= cnt + 1'b1;
            end else if (a_go) begin
                ptr_a <= 1'b0;
                // r0 is hardwired to zero: the request is consumed but never written
                if (port.a_wn != '0) begin
                    port.wreg   <= 1'b1;
                    port.wn     <= port.a_wn;
                    port.datain <= port.a_data;
                end
            end else if (b_go) begin
                ptr_a <= 1'b1;
                if (port.b_wn != '0) begin
                    port.wreg   <= 1'b1;
                    port.wn     <= port.b_wn;
                    port.datain <= port.b_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb/tb_regfile_wr_sched.sv - self-checking bench for the register-file write scheduler
module tb_regfile_wr_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    regfile_wr_sched_if ifc ();

    regfile_wr_sched dut (
        .clk   (clk),
        .reset (reset),
        .port  (ifc)
    );

    typedef struct {
        logic [4:0]  wn;
        logic [31:0] data;
    } req_t;

    req_t        qa[$];
    req_t        qb[$];
    logic [4:0]  glog[$];
    logic [31:0] shadow[32];
    logic [31:0] model[32];
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total = 0;
    bit          last_a;
    bit          hold_known;
    logic [4:0]  exp_wn;
    logic [31:0] exp_data;

    // register file as the write port would update it
    always @(posedge clk) begin
        if (ifc.wreg) shadow[ifc.wn] <= ifc.datain;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        ifc.a_valid = (qa.size() > 0);
        ifc.b_valid = (qb.size() > 0);
        if (qa.size() > 0) begin
            ifc.a_wn   = qa[0].wn;
            ifc.a_data = qa[0].data;
        end
        if (qb.size() > 0) begin
            ifc.b_wn   = qb[0].wn;
            ifc.b_data = qb[0].data;
        end
    endtask

    task automatic cycle();
        bit   ga;
        bit   gb;
        req_t r;
        drive();
        #1;
        ga = (qa.size() > 0) && ((qb.size() == 0) || !last_a);
        gb = (qb.size() > 0) && !ga;
        chk("a_ready", ifc.a_ready, ga);
        chk("b_ready", ifc.b_ready, gb);
        @(posedge clk);
        #1;
        chk("init_done_run", ifc.init_done, 1);
        if (ga || gb) begin
            r = ga ? qa.pop_front() : qb.pop_front();
            last_a = ga;
            glog.push_back(r.wn);
            if (r.wn != 0) begin
                model[r.wn] = r.data;
                exp_wn      = r.wn;
                exp_data    = r.data;
                hold_known  = 1'b1;
                chk("wreg_xfer", ifc.wreg, 1);
                chk("wn_xfer", ifc.wn, exp_wn);
                chk("datain_xfer", ifc.datain, exp_data);
            end else begin
                hold_known = 1'b0;
                chk("wreg_r0", ifc.wreg, 0);
            end
        end else begin
            chk("wreg_idle", ifc.wreg, 0);
            if (hold_known) begin
                chk("wn_hold", ifc.wn, exp_wn);
                chk("datain_hold", ifc.datain, exp_data);
            end
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        ifc.a_valid = 1'b1;
        ifc.b_valid = 1'b1;
        qa.delete();
        qb.delete();
        last_a     = 1'b0;
        hold_known = 1'b0;
        #1;
        chk("rst_wn", ifc.wn, 0);
        chk("rst_datain", ifc.datain, 0);
        chk("rst_wreg", ifc.wreg, 0);
        chk("rst_init_done", ifc.init_done, 0);
        chk("rst_a_ready", ifc.a_ready, 0);
        chk("rst_b_ready", ifc.b_ready, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic sweep(input int upto);
        for (int i = 1; i <= upto; i++) begin
            ifc.a_valid = 1'b1;
            ifc.b_valid = 1'b1;
            ifc.a_wn    = 5'($urandom_range(0, 31));
            ifc.b_wn    = 5'($urandom_range(0, 31));
            #1;
            chk("sweep_a_ready", ifc.a_ready, 0);
            chk("sweep_b_ready", ifc.b_ready, 0);
            @(posedge clk);
            #1;
            chk("sweep_wreg", ifc.wreg, 1);
            chk("sweep_wn", ifc.wn, i);
            chk("sweep_datain", ifc.datain, 0);
            chk("sweep_init_done", ifc.init_done, 0);
        end
        if (upto == 31) begin
            ifc.a_valid = 1'b0;
            ifc.b_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("post_sweep_wreg", ifc.wreg, 0);
            chk("post_sweep_init_done", ifc.init_done, 1);
            for (int i = 1; i < 32; i++) begin
                model[i] = 32'h0;
                chk($sformatf("swept_r%0d", i), shadow[i], 0);
            end
            exp_wn     = 5'd31;
            exp_data   = 32'h0;
            hold_known = 1'b1;
        end
    endtask

    task automatic check_order(input string tag, input logic [4:0] e0, input logic [4:0] e1,
                               input logic [4:0] e2, input logic [4:0] e3, input int n);
        logic [4:0] e[4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_count"}, glog.size(), n);
        if (glog.size() == n) begin
            for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", tag, i), glog[i], e[i]);
        end
    endtask

    initial begin
        ifc.a_valid = 1'b0;
        ifc.b_valid = 1'b0;
        ifc.a_wn    = '0;
        ifc.b_wn    = '0;
        ifc.a_data  = '0;
        ifc.b_data  = '0;
        for (int i = 0; i < 32; i++) begin
            shadow[i] = 32'hBAD0_0000 | i;
            model[i]  = 32'hBAD0_0000 | i;
        end
        model[0] = 32'hBAD0_0000;

        do_reset();
        sweep(31);

        qa.push_back('{5'd1, 32'hFFFF_FFFF});
        cycle();
        cycle();
        chk("r1_written", shadow[1], 32'hFFFF_FFFF);

        qb.push_back('{5'd0, 32'hDEAD_BEEF});
        cycle();
        cycle();
        chk("r0_untouched", shadow[0], 32'hBAD0_0000);

        glog.delete();
        qa.push_back('{5'd2, 32'h0000_F00F});
        qa.push_back('{5'd3, 32'hFF00_FF00});
        qb.push_back('{5'd4, 32'hAA00_00AA});
        qb.push_back('{5'd5, 32'h1234_5678});
        repeat (4) cycle();
        check_order("rr_order", 5'd2, 5'd4, 5'd3, 5'd5, 4);
        cycle();

        glog.delete();
        qa.push_back('{5'd7, 32'h1111_1111});
        qb.push_back('{5'd7, 32'h2222_2222});
        cycle();
        chk("r7_mid", ifc.datain, 32'h1111_1111);
        cycle();
        cycle();
        chk("r7_last_wins", shadow[7], 32'h2222_2222);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) != 0 && qa.size() < 3)
                qa.push_back('{5'($urandom_range(0, 31)), 32'($urandom)});
            if ($urandom_range(0, 2) != 0 && qb.size() < 3)
                qb.push_back('{5'($urandom_range(0, 31)), 32'($urandom)});
            cycle();
        end
        for (int n = 0; n < 20 && (qa.size() > 0 || qb.size() > 0); n++) cycle();
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        cycle();
        for (int i = 0; i < 32; i++) chk($sformatf("regfile_r%0d", i), shadow[i], model[i]);

        do_reset();
        sweep(10);
        reset = 1'b1;
        #1;
        chk("midsweep_wn", ifc.wn, 0);
        chk("midsweep_wreg", ifc.wreg, 0);
        chk("midsweep_datain", ifc.datain, 0);
        chk("midsweep_init_done", ifc.init_done, 0);
        @(negedge clk);
        reset = 1'b0;
        sweep(31);
        qa.push_back('{5'd9, 32'hCAFE_F00D});
        cycle();
        cycle();
        chk("r9_after_restart", shadow[9], 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
